// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// Covers the state enum, opcodes, ALUOp codes and the datapath mux-select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXECUTE = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JUMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mc_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  op, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal_op, instr_done
    );

    modport slave (
        output op, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal_op, instr_done
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control: Moore FSM whose outputs decode from state,
// with mem_ready gating the fetch/store completion strobes.
module mc_control
    import mc_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mc_control_if.master bus
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;

    // The IR may change after DECODE, so MEMADR steers on the captured opcode.
    assign op_d = (state_q == DECODE) ? bus.op : op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.pc_src     = PCSRC_ALU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.alu_op     = ALUOP_ADD;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.illegal_op = 1'b0;
        bus.instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b = SRCB_IMM_SL2;
                case (bus.op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ;
                    default: begin
                        bus.illegal_op = 1'b1;
                        bus.instr_done = 1'b1;
                    end
                endcase
            end
            MEMADR, ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEMWR: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                bus.reg_dst    = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = ALUOP_SUB;
                bus.pc_src     = PCSRC_ALUOUT;
                bus.branch     = 1'b1;
                bus.instr_done = 1'b1;
            end
            ADDIWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            JUMP: begin
                bus.pc_src     = PCSRC_JUMP;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: every cycle pushes the expected output vector
// for that cycle, and the vector is popped and compared at the falling edge.
module tb_mc_control;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mc_control_if bus_if ();

    mc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    // Field order: mem_read mem_write i_or_d ir_write pc_write branch pc_src
    // alu_src_a alu_src_b alu_op reg_dst mem_to_reg reg_write illegal_op instr_done
    function automatic logic [17:0] mk(
        input logic mr, input logic mw, input logic iod, input logic irw,
        input logic pcw, input logic br, input logic [1:0] pcs, input logic asa,
        input logic [1:0] asb, input logic [1:0] aop, input logic rd,
        input logic m2r, input logic rw, input logic ill, input logic done);
        return {mr, mw, iod, irw, pcw, br, pcs, asa, asb, aop, rd, m2r, rw, ill, done};
    endfunction

    function automatic logic [17:0] observed();
        return {bus_if.mem_read, bus_if.mem_write, bus_if.i_or_d, bus_if.ir_write,
                bus_if.pc_write, bus_if.branch, bus_if.pc_src, bus_if.alu_src_a,
                bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_dst, bus_if.mem_to_reg,
                bus_if.reg_write, bus_if.illegal_op, bus_if.instr_done};
    endfunction

    logic [17:0] e_zero, e_fetch_w, e_fetch_h, e_decode, e_decode_ill, e_memadr;
    logic [17:0] e_memrd, e_memwb, e_memwr_w, e_memwr_d, e_exec, e_aluwb;
    logic [17:0] e_branch, e_addiex, e_addiwb, e_jump;

    task automatic check_pop();
        logic [17:0] e;
        logic [17:0] o;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        checks++;
        $display("t=%0t %s obs=%05h exp=%05h", $time, t, o, e);
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", t, o, e);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare mid-cycle.
    task automatic cyc(input logic mr, input logic [5:0] o, input logic [17:0] e,
                       input string t);
        bus_if.mem_ready = mr;
        bus_if.op        = o;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        e_zero       = '0;
        e_fetch_w    = mk(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
        e_fetch_h    = mk(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
        e_decode     = mk(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,0);
        e_decode_ill = mk(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,1,1);
        e_memadr     = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0);
        e_memrd      = mk(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
        e_memwb      = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,0,1);
        e_memwr_w    = mk(0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
        e_memwr_d    = mk(0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1);
        e_exec       = mk(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,0);
        e_aluwb      = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0,1);
        e_branch     = mk(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0,1);
        e_addiex     = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0);
        e_addiwb     = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,0,1);
        e_jump       = mk(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0,1);

        rst = 1'b1;
        bus_if.mem_ready = 1'b1;
        bus_if.op = 6'b000000;
        exp_q.push_back(e_zero);
        tag_q.push_back("reset_hold");
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type: IDLE, FETCH, DECODE, EXECUTE, ALUWB
        cyc(1, 6'b000000, e_zero,    "rtype_idle");
        cyc(1, 6'b000000, e_fetch_w, "rtype_fetch");
        cyc(1, 6'b000000, e_decode,  "rtype_decode");
        cyc(1, 6'b111111, e_exec,    "rtype_execute");
        cyc(1, 6'b111111, e_aluwb,   "rtype_aluwb");

        // lw with one fetch stall and three MEMRD stalls; op changes after DECODE
        cyc(0, 6'b100011, e_fetch_h, "lw_fetch_stall");
        cyc(1, 6'b100011, e_fetch_w, "lw_fetch");
        cyc(1, 6'b100011, e_decode,  "lw_decode");
        cyc(1, 6'b101011, e_memadr,  "lw_memadr");
        cyc(0, 6'b101011, e_memrd,   "lw_memrd_s1");
        cyc(0, 6'b101011, e_memrd,   "lw_memrd_s2");
        cyc(0, 6'b101011, e_memrd,   "lw_memrd_s3");
        cyc(1, 6'b101011, e_memrd,   "lw_memrd_go");
        cyc(1, 6'b101011, e_memwb,   "lw_memwb");

        // sw with one MEMWR stall; op changes to lw after DECODE
        cyc(1, 6'b101011, e_fetch_w, "sw_fetch");
        cyc(1, 6'b101011, e_decode,  "sw_decode");
        cyc(1, 6'b100011, e_memadr,  "sw_memadr");
        cyc(0, 6'b100011, e_memwr_w, "sw_memwr_stall");
        cyc(1, 6'b100011, e_memwr_d, "sw_memwr_done");

        cyc(1, 6'b000100, e_fetch_w, "beq_fetch");
        cyc(1, 6'b000100, e_decode,  "beq_decode");
        cyc(1, 6'b000100, e_branch,  "beq_branch");

        cyc(1, 6'b000010, e_fetch_w, "j_fetch");
        cyc(1, 6'b000010, e_decode,  "j_decode");
        cyc(1, 6'b000010, e_jump,    "j_jump");

        cyc(1, 6'b001000, e_fetch_w, "addi_fetch");
        cyc(1, 6'b001000, e_decode,  "addi_decode");
        cyc(1, 6'b001000, e_addiex,  "addi_ex");
        cyc(1, 6'b001000, e_addiwb,  "addi_wb");

        cyc(1, 6'b111111, e_fetch_w,    "ill_fetch");
        cyc(1, 6'b111111, e_decode_ill, "ill_decode");
        cyc(1, 6'b000000, e_fetch_w,    "ill_back_fetch");
        cyc(1, 6'b000000, e_decode,     "post_ill_decode");
        cyc(1, 6'b000000, e_exec,       "post_ill_execute");
        cyc(1, 6'b000000, e_aluwb,      "post_ill_aluwb");

        // Reset during a stalled store
        cyc(1, 6'b101011, e_fetch_w, "rst_sw_fetch");
        cyc(1, 6'b101011, e_decode,  "rst_sw_decode");
        cyc(1, 6'b101011, e_memadr,  "rst_sw_memadr");
        cyc(0, 6'b101011, e_memwr_w, "rst_sw_memwr");
        bus_if.mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.push_back(e_zero);
        tag_q.push_back("rst_async_drop");
        #1;
        check_pop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 6'b000000, e_zero,    "rel_idle");
        cyc(1, 6'b000000, e_fetch_w, "rel_fetch");
        cyc(1, 6'b000000, e_decode,  "rel_decode");
        cyc(1, 6'b000000, e_exec,    "rel_execute");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode from the instruction register and steps through fetch, decode, execute, memory and writeback states. In each state it drives the datapath mux selects, write enables and the 2-bit ALUOp consumed by the ALU control unit. It sits between the instruction register and the datapath, and issues the ALUOp encodings 00 (add), 01 (subtract) and 10 (use funct).

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  6  opcode, IR[31:26]; sampled only in DECODE.
- `mem_ready`  in  1  memory access complete this cycle.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  unconditional PC load.
- `branch`  out  1  conditional PC load, gated by ALU zero in the datapath.
- `pc_src`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.

## Operation
- Moore FSM with a 4-bit state register. All outputs are decoded combinationally from state; `mem_ready` additionally gates some of them.
- Reset: state = IDLE, so every output is 0. IDLE always moves to FETCH on the next edge.
- Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Any other opcode → FETCH, with illegal_op=1 and instr_done=1 this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready; on that cycle instr_done=1 and next state is FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Goes to FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. Goes to FETCH.
- The opcode captured in DECODE is held in a 6-bit register, because MEMADR branches on lw vs sw after the IR may be stale. That register resets to 0.
- Unused state encodings go to IDLE.

## Timing
- Cycle counts with mem_ready tied to 1, from FETCH entry to the instr_done cycle inclusive:
  - j: 3
  - beq: 3
  - R-type: 4
  - addi: 4
  - sw: 4
  - lw: 5
  - illegal opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- ir_write and pc_write pulse exactly once per fetch, in the cycle mem_ready=1.
- rst asserted mid-instruction: outputs drop to 0 immediately (asynchronously). No partial write completes after rst rises.
- After rst deasserts, the first rising edge enters FETCH.
- alu_op is never 11.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - state enum: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
  - alu_src_b and pc_src constants.
- Single module; no sub-module needed. Next-state and output decode are two combinational processes beside the state and opcode registers.

## Test plan
- Reset, mem_ready=1, op=000000: state sequence IDLE, FETCH, DECODE, EXECUTE, ALUWB.
  - EXECUTE drives alu_op=10.
  - ALUWB drives reg_write=1, reg_dst=1, instr_done=1.
  - Back in FETCH on cycle 5.
- op=100011 with mem_ready held low 3 cycles in MEMRD:
  - mem_read=1 and i_or_d=1 held for all 4 MEMRD cycles.
  - Then MEMWB with mem_to_reg=1, reg_write=1.
  - Total 8 cycles.
- op=101011: MEMWR drives mem_write=1 and instr_done=1 in the same cycle; reg_write never rises.
- op=000100, then op=000010:
  - BRANCH drives alu_op=01, pc_src=01, branch=1.
  - JUMP drives pc_src=10, pc_write=1.
  - Each takes 3 cycles.
- op=111111: illegal_op=1 for exactly one DECODE cycle, then FETCH; no reg_write or mem_write.
- rst asserted during MEMWR with mem_write=1: mem_write falls in the same cycle; after release, FETCH with pc_write=1 exactly once.
